serial_lane_arbiter: RTL
========================

Name: serial_lane_arbiter

Overview:
- Shares one serial-to-parallel deserializer among N_CH serial requesters.
- A requester is granted the deserializer for exactly one WIDTH-bit word. The block collects that word LSB-first and emits it with the source channel id.
- Round-robin arbitration. A configurable idle timeout aborts a stalled word so that a dead requester cannot starve the others.
- Sits between the serial lane front-ends and the parallel word consumer.

Parameters:
- N_CH, default 4: number of serial requesters (≥2).
- WIDTH, default 8: bits per assembled word (≥2).
- TIMEOUT, default 16: maximum consecutive idle cycles of the granted lane before abort. 0 disables the timeout.

Ports:
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- serial_valid  in  N_CH: per-lane bit-valid.
- serial_data  in  N_CH: per-lane serial bit.
- serial_ready  out  N_CH: per-lane accept; one-hot or zero.
- parallel_valid  out  1: one-cycle pulse, word complete.
- parallel_data  out  WIDTH: assembled word; the first accepted bit is in bit 0.
- parallel_id  out  $clog2(N_CH): source lane of parallel_data.
- abort  out  1: one-cycle pulse, word dropped on timeout.
- abort_id  out  $clog2(N_CH): lane that timed out.

Behaviour:
- Reset (async assert, sync-release use) clears all of the following:
  - state=IDLE, serial_ready=0, parallel_valid=0, parallel_data=0, parallel_id=0, abort=0, abort_id=0.
  - Shift register, bit count and idle counter = 0.
  - last_grant = N_CH-1, so lane 0 has highest priority first.
- Reset mid-word: the partial word is discarded and no output pulse is produced.
- Bit transfer on lane i only when serial_valid[i] && serial_ready[i] on a rising edge.
- IDLE state:
  - serial_ready = 0.
  - If any serial_valid is set, grant the first requesting lane searching from (last_grant+1) mod N_CH upward with wrap.
  - Register the grant and go to COLLECT, with bit count and idle counter cleared.
  - If no lane is valid, stay in IDLE.
- COLLECT state:
  - serial_ready[grant] = 1; all other ready bits are 0.
  - On each accepted bit: shift right, inserting the bit at MSB; bit count +1; idle counter cleared.
  - On the WIDTH-th accepted bit:
    - Next cycle: parallel_valid=1, parallel_data=full word, parallel_id=grant.
    - last_grant <= grant; state goes to IDLE.
  - Latency: parallel_valid one cycle after the last bit edge.
  - Cycle with no accepted bit: idle counter +1.
  - If TIMEOUT≠0 and the idle counter reaches TIMEOUT:
    - Next cycle: abort=1, abort_id=grant, parallel_valid=0.
    - Partial word discarded; last_grant <= grant; state goes to IDLE.
- Simultaneous bit acceptance and timeout threshold: the bit wins, the counter clears and there is no abort.
- Minimum spacing between grants is one IDLE cycle. Back-to-back words from the same lane are allowed only if no other lane is requesting.
- Valid bits on non-granted lanes are ignored; they are not lost, because their ready is 0.
- parallel_data and parallel_id hold their values between pulses. abort_id holds its value between aborts.
- Counter widths: bit count $clog2(WIDTH+1); idle counter $clog2(TIMEOUT+1), minimum 1.

Decomposition:
- Package serial_lane_arbiter_pkg:
  - state enum {IDLE, COLLECT}.
  - Function for the lane-id width.
- Sub-module rr_arbiter (N_CH):
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant, grant index and any_req.
  - Purely combinational.
- The FSM, counters and shift register live in the top level.

Test Plan:
- Reset then lane 2 only sends 8 bits 1,0,1,1,0,0,1,0 → parallel_valid pulse with parallel_data=8'h4D, parallel_id=2; serial_ready[2] high exactly 8 accepted cycles.
- All 4 lanes valid continuously → grants in order 0,1,2,3,0; each word is tagged with the correct id; no ready overlap; one IDLE gap between words.
- Lane 1 granted, sends 3 bits then drops valid for 16 cycles (TIMEOUT=16) → abort pulse with abort_id=1, no parallel_valid; next grant goes to lane 2 if it is requesting.
- Lane 0 stalls for 15 cycles, then resumes for the remaining 5 bits → no abort; word delivered intact.
- Assert rst_n low mid-word after 5 bits → all outputs 0 immediately; after release, lane 0 has priority and no stale bits appear in its next word.
- Lane 3 toggles serial_valid every other cycle → the word completes after 15–16 cycles with correct data; no timeout.

Source files
------------

// File: rtl/serial_lane_arbiter_pkg.sv
// rtl/serial_lane_arbiter_pkg.sv - shared types and helpers for the serial lane arbiter
`timescale 1ns/1ps
package serial_lane_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_lane_arbiter_rr_arbiter.sv
// rtl/serial_lane_arbiter_rr_arbiter.sv - combinational round-robin pick starting after last_grant
`timescale 1ns/1ps
module rr_arbiter
  import serial_lane_arbiter_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]           req_i,
  input  logic [id_width(N_CH)-1:0] last_grant_i,
  output logic [N_CH-1:0]           gnt_o,
  output logic [id_width(N_CH)-1:0] gnt_idx_o,
  output logic                      any_req_o
);

  localparam int IDW = id_width(N_CH);

  logic [IDW-1:0] cand;
  logic           found;

  assign any_req_o = |req_i;

  // Walk lanes last_grant+1 .. last_grant+N_CH (wrapping); first requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= N_CH; off++) begin
      cand = IDW'((int'(last_grant_i) + off) % N_CH);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/serial_lane_arbiter.sv
// rtl/serial_lane_arbiter.sv - shares one LSB-first deserializer among N_CH serial lanes
`timescale 1ns/1ps
module serial_lane_arbiter
  import serial_lane_arbiter_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           serial_valid,
  input  logic [N_CH-1:0]           serial_data,
  output logic [N_CH-1:0]           serial_ready,
  output logic                      parallel_valid,
  output logic [WIDTH-1:0]          parallel_data,
  output logic [id_width(N_CH)-1:0] parallel_id,
  output logic                      abort,
  output logic [id_width(N_CH)-1:0] abort_id
);

  localparam int IDW = id_width(N_CH);
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int ICW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e           state_q, state_d;
  logic [N_CH-1:0]  grant_oh_q, grant_oh_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [ICW-1:0]   idle_q, idle_d;
  logic             pvalid_q, pvalid_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic [IDW-1:0]   pid_q, pid_d;
  logic             abort_q, abort_d;
  logic [IDW-1:0]   abort_id_q, abort_id_d;

  logic [N_CH-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;
  logic             accept;
  logic             bit_in;
  logic [ICW-1:0]   idle_inc;
  logic             timeout_hit;

  rr_arbiter #(
    .N_CH(N_CH)
  ) u_rr_arbiter (
    .req_i       (serial_valid),
    .last_grant_i(last_grant_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .any_req_o   (arb_any)
  );

  // Ready comes straight from the registered one-hot grant.
  assign serial_ready = (state_q == COLLECT) ? grant_oh_q : '0;
  assign accept       = |(serial_valid & serial_ready);
  assign bit_in       = |(serial_data & grant_oh_q);
  assign idle_inc     = idle_q + ICW'(1);
  assign timeout_hit  = (TIMEOUT != 0) && (idle_inc == ICW'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    grant_oh_d   = grant_oh_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    idle_d       = idle_q;
    pvalid_d     = 1'b0;
    pdata_d      = pdata_q;
    pid_d        = pid_q;
    abort_d      = 1'b0;
    abort_id_d   = abort_id_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_oh_d = arb_gnt;
          grant_d    = arb_idx;
          shift_d    = '0;
          bitcnt_d   = '0;
          idle_d     = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          // A bit arriving on the threshold cycle always beats the timeout.
          shift_d  = {bit_in, shift_q[WIDTH-1:1]};
          bitcnt_d = bitcnt_q + BCW'(1);
          idle_d   = '0;
          if (bitcnt_q == BCW'(WIDTH - 1)) begin
            pvalid_d     = 1'b1;
            pdata_d      = {bit_in, shift_q[WIDTH-1:1]};
            pid_d        = grant_q;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end else if (timeout_hit) begin
          abort_d      = 1'b1;
          abort_id_d   = grant_q;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          idle_d = idle_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_oh_q   <= '0;
      grant_q      <= '0;
      last_grant_q <= IDW'(N_CH - 1);
      shift_q      <= '0;
      bitcnt_q     <= '0;
      idle_q       <= '0;
      pvalid_q     <= 1'b0;
      pdata_q      <= '0;
      pid_q        <= '0;
      abort_q      <= 1'b0;
      abort_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_oh_q   <= grant_oh_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      idle_q       <= idle_d;
      pvalid_q     <= pvalid_d;
      pdata_q      <= pdata_d;
      pid_q        <= pid_d;
      abort_q      <= abort_d;
      abort_id_q   <= abort_id_d;
    end
  end

  assign parallel_valid = pvalid_q;
  assign parallel_data  = pdata_q;
  assign parallel_id    = pid_q;
  assign abort          = abort_q;
  assign abort_id       = abort_id_q;

endmodule
